// File: rtl/abs_value_pkg.sv
// -----------------------------------------------------------------------------
// abs_value_pkg
//   Shared types, limits and the absolute-value/saturation function used by the
//   pipelined absolute-value unit (and intended for reuse by vector ALU lanes).
//
//   Contents:
//     MAX_W, WIDTH_MIN/MAX, STAGES_MIN/MAX  legal parameter limits
//     abs_flags_t                          per-beat status flags {neg, ovf}
//     abs_result_t                         {data[MAX_W], flags}
//     abs_sat()                            magnitude + flags for a WIDTH-bit operand
// -----------------------------------------------------------------------------
package abs_value_pkg;

    localparam int unsigned MAX_W      = 64;
    localparam int unsigned WIDTH_MIN  = 2;
    localparam int unsigned WIDTH_MAX  = 64;
    localparam int unsigned STAGES_MIN = 1;
    localparam int unsigned STAGES_MAX = 4;

    typedef struct packed {
        logic neg;
        logic ovf;
    } abs_flags_t;

    typedef struct packed {
        logic [MAX_W-1:0] data;
        abs_flags_t       flags;
    } abs_result_t;

    // Operand occupies data[width-1:0]; the result magnitude occupies the same
    // bits and everything above is returned as zero. The signed minimum either
    // clamps to the largest positive value or is reported as the unsigned
    // magnitude 2^(width-1).
    function automatic abs_result_t abs_sat(
        input logic [MAX_W-1:0] data,
        input int unsigned      width,
        input logic             is_signed,
        input logic             saturate
    );
        abs_result_t      r;
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] msb;
        logic [MAX_W-1:0] mag;
        logic             neg;
        logic             ovf;

        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        msb  = MAX_W'(1) << (width - 1);
        neg  = is_signed & ((data & msb) != '0);
        // mask >> 1 selects every operand bit below the sign bit
        ovf  = neg & ((data & (mask >> 1)) == '0);
        mag  = neg ? ((~data + MAX_W'(1)) & mask) : (data & mask);
        if (ovf && saturate) begin
            mag = msb - MAX_W'(1);
        end
        r.data      = mag;
        r.flags.neg = neg;
        r.flags.ovf = ovf;
        return r;
    endfunction

endpackage

// File: rtl/abs_value_pipe_stage.sv
// -----------------------------------------------------------------------------
// abs_pipe_stage
//   One valid/ready register slice. Ready is combinational (!valid | downstream
//   ready), so a chain of these slices runs at full throughput and collapses
//   bubbles under backpressure.
//
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     up_valid_i    upstream beat valid
//     up_data_i     upstream payload [PW]
//     up_ready_o    slice can take a beat this cycle
//     dn_valid_o    slice holds a beat
//     dn_data_o     held payload [PW]
//     dn_ready_i    downstream accepts the held beat
// -----------------------------------------------------------------------------
module abs_pipe_stage #(
    parameter int PW = 34
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid_i,
    input  logic [PW-1:0] up_data_i,
    output logic          up_ready_o,
    output logic          dn_valid_o,
    output logic [PW-1:0] dn_data_o,
    input  logic          dn_ready_i
);

    logic          valid_q, valid_d;
    logic [PW-1:0] data_q, data_d;

    assign up_ready_o = !valid_q || dn_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (up_ready_o) begin
            valid_d = up_valid_i;
            // Payload holds across bubbles so the output stays quiet.
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    // ---- slice register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

endmodule

// File: rtl/abs_value_pipe.sv
// -----------------------------------------------------------------------------
// abs_value_pipe
//   Pipelined absolute-value unit with valid/ready handshake. The magnitude and
//   flags are computed combinationally on the input beat and then carried
//   through STAGES register slices; latency is STAGES cycles, throughput one
//   beat per cycle.
//
//   Parameters: WIDTH (2..64), STAGES (1..4), SATURATE (clamp signed minimum)
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     in_valid/in_ready     input handshake
//     in_data [WIDTH]       operand
//     in_signed             1: two's complement operand, 0: unsigned pass-through
//     out_valid/out_ready   output handshake
//     out_data [WIDTH]      magnitude
//     out_neg               operand was negative
//     out_ovf               operand was the signed minimum
// -----------------------------------------------------------------------------
module abs_value_pipe
    import abs_value_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int STAGES   = 2,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_neg,
    output logic             out_ovf
);

    localparam int PW = WIDTH + 2;

    if (WIDTH < int'(WIDTH_MIN) || WIDTH > int'(WIDTH_MAX) ||
        STAGES < int'(STAGES_MIN) || STAGES > int'(STAGES_MAX)) begin : g_bad_param
        $error("abs_value_pipe: WIDTH or STAGES out of range");
    end

    logic [MAX_W-1:0] in_ext;
    abs_result_t      res_d;
    logic [PW-1:0]    payload_d;

    assign in_ext = MAX_W'(in_data);

    always_comb begin
        res_d = abs_sat(in_ext, WIDTH, in_signed, SATURATE);
    end

    assign payload_d = {res_d.data[WIDTH-1:0], res_d.flags.neg, res_d.flags.ovf};

    // The function zeroes bits above WIDTH; they are intentionally dropped.
    if (WIDTH < int'(MAX_W)) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^res_d.data[MAX_W-1:WIDTH];
    end

    // Index k is the input side of slice k; index STAGES is the output port.
    logic [STAGES:0]         vld_p;
    logic [STAGES:0]         rdy_p;
    logic [STAGES:0][PW-1:0] dat_p;

    assign vld_p[0]      = in_valid;
    assign dat_p[0]      = payload_d;
    assign rdy_p[STAGES] = out_ready;
    assign in_ready      = rdy_p[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // ---- pipeline stage k ----
        abs_pipe_stage #(
            .PW(PW)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_valid_i (vld_p[k]),
            .up_data_i  (dat_p[k]),
            .up_ready_o (rdy_p[k]),
            .dn_valid_o (vld_p[k+1]),
            .dn_data_o  (dat_p[k+1]),
            .dn_ready_i (rdy_p[k+1])
        );
    end

    assign out_valid                     = vld_p[STAGES];
    assign {out_data, out_neg, out_ovf}  = dat_p[STAGES];

endmodule

// File: tb/tb_abs_value_pipe.sv
module tb_abs_value_pipe;

    typedef struct {
        logic [63:0] data;
        logic        neg;
        logic        ovf;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] in_data;
        logic        in_signed;
        logic [31:0] exp_data;
        logic        exp_neg;
        logic        exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // 32-bit, 2 stages: saturating (a) and non-saturating (b) share stimulus
    logic        a_in_valid = 1'b0, a_in_signed = 1'b0, a_out_ready = 1'b1;
    logic [31:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid, a_out_neg, a_out_ovf;
    logic [31:0] a_out_data;
    logic        b_in_ready, b_out_valid, b_out_neg, b_out_ovf;
    logic [31:0] b_out_data;
    // 8-bit, 1 stage
    logic        c_in_valid = 1'b0, c_in_signed = 1'b0, c_out_ready = 1'b1;
    logic [7:0]  c_in_data = '0;
    logic        c_in_ready, c_out_valid, c_out_neg, c_out_ovf;
    logic [7:0]  c_out_data;

    abs_value_pipe #(.WIDTH(32), .STAGES(2), .SATURATE(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_signed(a_in_signed), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_neg(a_out_neg), .out_ovf(a_out_ovf));

    abs_value_pipe #(.WIDTH(32), .STAGES(2), .SATURATE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(b_in_ready),
        .in_data(a_in_data), .in_signed(a_in_signed), .out_valid(b_out_valid),
        .out_ready(a_out_ready), .out_data(b_out_data), .out_neg(b_out_neg), .out_ovf(b_out_ovf));

    abs_value_pipe #(.WIDTH(8), .STAGES(1), .SATURATE(1'b1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_signed(c_in_signed), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_neg(c_out_neg), .out_ovf(c_out_ovf));

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    logic strict_a = 1'b1;
    logic strict_c = 1'b1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: two's complement negation by subtraction from 2^w.
    function automatic logic [65:0] model(input int w, input bit sat, input logic [63:0] d,
                                          input logic sgn);
        logic [63:0] mag;
        if (!sgn || !d[w-1]) return {d, 2'b00};
        mag = (64'd1 << w) - d;
        if (mag == (64'd1 << (w - 1))) return {(sat ? mag - 64'd1 : mag), 2'b11};
        return {mag, 2'b10};
    endfunction

    // Drive one beat from posedge+1, hold until accepted, push its expectation.
    task automatic send(input bit to_c, input logic [63:0] d, input logic sgn,
                        input logic [63:0] ed, input logic en, input logic eo);
        exp_t e;
        if (to_c) begin
            c_in_valid = 1'b1; c_in_data = d[7:0]; c_in_signed = sgn;
        end else begin
            a_in_valid = 1'b1; a_in_data = d[31:0]; a_in_signed = sgn;
        end
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (to_c ? c_in_ready : a_in_ready) begin
                e.data = ed; e.neg = en; e.ovf = eo; e.cyc = cyc;
                if (to_c) qc.push_back(e); else qa.push_back(e);
                @(posedge clk); #1;
                return;
            end
        end
        n_cmp++; n_fail++;
        $display("FAIL send_timeout: got no in_ready expected in_ready=1");
        if (to_c) c_in_valid = 1'b0; else a_in_valid = 1'b0;
    endtask

    task automatic idle();
        a_in_valid = 1'b0;
        c_in_valid = 1'b0;
    endtask

    // ---- monitors ----
    logic        a_stall_q = 1'b0;
    logic [33:0] a_hold_q  = '0;

    always @(negedge clk) begin
        exp_t e;
        logic [65:0] m;
        if (rst) begin
            a_stall_q <= 1'b0;
        end else begin
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) check("a_spurious", 1, 0);
                else begin
                    e = qa.pop_front();
                    check("a_beat", {a_out_data, a_out_neg, a_out_ovf}, {e.data[31:0], e.neg, e.ovf});
                    if (strict_a) check("a_latency", cyc - e.cyc, 2);
                end
            end
            if (b_out_valid && a_out_ready) begin
                if (qb.size() == 0) check("b_spurious", 1, 0);
                else begin
                    e = qb.pop_front();
                    check("b_beat", {b_out_data, b_out_neg, b_out_ovf}, {e.data[31:0], e.neg, e.ovf});
                end
            end
            if (a_in_valid && b_in_ready) begin
                m = model(32, 1'b0, {32'd0, a_in_data}, a_in_signed);
                e.data = m[65:2]; e.neg = m[1]; e.ovf = m[0]; e.cyc = cyc;
                qb.push_back(e);
            end
            if (a_stall_q) check("a_stall_hold", {a_out_valid, a_out_data, a_out_neg, a_out_ovf},
                                 {1'b1, a_hold_q});
            a_stall_q <= a_out_valid && !a_out_ready;
            a_hold_q  <= {a_out_data, a_out_neg, a_out_ovf};
            if (c_out_valid && c_out_ready) begin
                if (qc.size() == 0) check("c_spurious", 1, 0);
                else begin
                    e = qc.pop_front();
                    check("c_beat", {c_out_data, c_out_neg, c_out_ovf}, {e.data[7:0], e.neg, e.ovf});
                    if (strict_c) check("c_latency", cyc - e.cyc, 1);
                end
            end
        end
    end

    task automatic drain();
        for (int t = 0; t < 50 && (qa.size() + qb.size() + qc.size()) != 0; t++) @(posedge clk);
        #1;
        check("drain_empty", qa.size() + qb.size() + qc.size(), 0);
    endtask

    vec_t vecs[10];

    initial begin
        logic [65:0] m;
        logic [7:0]  r;
        logic        s;
        int          t0;

        vecs[0] = '{32'h0000000F, 1'b1, 32'h0000000F, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFF1, 1'b1, 32'h0000000F, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[3] = '{32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[4] = '{32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0};
        vecs[5] = '{32'h80000000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[6] = '{32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 1'b1, 32'h00000001, 1'b1, 1'b0};
        vecs[8] = '{32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0};
        vecs[9] = '{32'h80000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_a_out", {a_out_valid, a_out_data, a_out_neg, a_out_ovf}, 0);
        check("rst_c_out", {c_out_valid, c_out_data, c_out_neg, c_out_ovf}, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {a_in_ready, b_in_ready, c_in_ready}, 3'b111);
        @(posedge clk); #1;

        // Table vectors, back to back
        for (int i = 0; i < 10; i++)
            send(1'b0, {32'd0, vecs[i].in_data}, vecs[i].in_signed,
                 {32'd0, vecs[i].exp_data}, vecs[i].exp_neg, vecs[i].exp_ovf);
        idle();
        drain();

        // Stream -1..-8 with a 5-cycle downstream stall
        @(posedge clk); #1;
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send(1'b0, 64'(-i) & 64'hFFFF_FFFF, 1'b1, 64'(i), 1'b1, 1'b0);
                idle();
            end
            begin
                strict_a = 1'b0;
                repeat (3) @(posedge clk);
                #2 a_out_ready = 1'b0;
                repeat (5) @(negedge clk);
                check("stall_in_ready_low", a_in_ready, 1'b0);
                check("stall_out_valid", a_out_valid, 1'b1);
                @(posedge clk); #2 a_out_ready = 1'b1;
            end
        join
        drain();
        strict_a = 1'b1;

        // Reset with two beats in flight
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        send(1'b0, 64'h0000_0005, 1'b1, 64'h5, 1'b0, 1'b0);
        send(1'b0, 64'hFFFF_FFFB, 1'b1, 64'h5, 1'b1, 1'b0);
        idle();
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", {a_out_valid, b_out_valid}, 2'b00);
        check("arst_out_data", {a_out_data, a_out_neg, a_out_ovf}, 0);
        qa.delete(); qb.delete();
        #3 rst = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        check("arst_in_ready", a_in_ready, 1'b1);
        repeat (5) @(posedge clk);
        #1;

        // 8-bit, single stage
        send(1'b1, 64'h80, 1'b1, 64'h7F, 1'b1, 1'b1);
        send(1'b1, 64'hFE, 1'b1, 64'h02, 1'b1, 1'b0);
        send(1'b1, 64'hFE, 1'b0, 64'hFE, 1'b0, 1'b0);
        idle();
        drain();
        @(posedge clk); #1;
        t0 = cyc;
        for (int i = 0; i < 256; i++) begin
            r = 8'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            m = model(8, 1'b1, {56'd0, r}, s);
            send(1'b1, {56'd0, r}, s, m[65:2], m[1], m[0]);
        end
        check("c_throughput", cyc - t0, 256);
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
